// File: rtl/iterative_right_shifter_if.sv
// Request/result handshake bundle for iterative_right_shifter.
interface iterative_right_shifter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [4:0]       shamt;
  logic             arith;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] S;
  logic             busy;

  modport master (
    output start_valid, A, shamt, arith, result_ready,
    input  start_ready, result_valid, S, busy
  );

  modport slave (
    input  start_valid, A, shamt, arith, result_ready,
    output start_ready, result_valid, S, busy
  );
endinterface

// File: rtl/iterative_right_shifter.sv
// Multi-cycle right shifter: one binary-weighted stage (16/8/4/2/1) per clock.
// Define ARITH_SHIFT_EN to honour `arith` (sign fill); otherwise logical only.
module iterative_right_shifter #(
  parameter int unsigned WIDTH = 32
) (
  input logic                     clock,
  input logic                     reset_n,
  iterative_right_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [4:0]       rem_q, rem_d;
  logic             fill;

  function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] x,
                                                input logic             f,
                                                input int unsigned      n);
    logic signed [WIDTH:0] ext;
    ext = $signed({f, x}) >>> n;
    return ext[WIDTH-1:0];
  endfunction

`ifdef ARITH_SHIFT_EN
  logic fill_q, fill_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fill_q <= 1'b0;
    else          fill_q <= fill_d;
  end

  always_comb begin
    fill_d = fill_q;
    if (state_q == IDLE && bus.start_valid)
      fill_d = bus.arith & bus.A[WIDTH-1];
  end

  assign fill = fill_q;
`else
  logic unused_arith;
  assign unused_arith = bus.arith;
  assign fill         = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          work_d  = bus.A;
          rem_d   = bus.shamt;
          state_d = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // Highest remaining weight first; each stage clears its own bit.
        casez (rem_q)
          5'b1????: begin work_d = shr_fill(work_q, fill, 16); rem_d = {1'b0, rem_q[3:0]}; end
          5'b01???: begin work_d = shr_fill(work_q, fill, 8);  rem_d = {2'b0, rem_q[2:0]}; end
          5'b001??: begin work_d = shr_fill(work_q, fill, 4);  rem_d = {3'b0, rem_q[1:0]}; end
          5'b0001?: begin work_d = shr_fill(work_q, fill, 2);  rem_d = {4'b0, rem_q[0]};   end
          5'b00001: begin work_d = shr_fill(work_q, fill, 1);  rem_d = '0;                 end
          default:  rem_d = '0;
        endcase
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.S            = work_q;

endmodule
